// File: rtl/set_pkg.sv
// Shared constants for the lattice set counter: mode codes,
// FSM state encoding and width helpers.
package set_pkg;

  localparam logic [2:0] MODE_C0  = 3'b000;
  localparam logic [2:0] MODE_AND = 3'b001;
  localparam logic [2:0] MODE_XOR = 3'b010;
  localparam logic [2:0] MODE_OR  = 3'b011;
  localparam logic [2:0] MODE_KOF = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Point issue reg, d2 reg and accumulator each add one cycle
  // after the last point leaves the scan counter.
  localparam int DRAIN_CYC = 3;

  function automatic int cnt_w(input int grid);
    return $clog2(grid * grid + 1);
  endfunction

  function automatic int th_w(input int ncirc);
    return $clog2(ncirc + 1);
  endfunction

endpackage

// File: rtl/set_counter_multi_if.sv
// Job/result bus of the set counter. master = requester,
// slave = counter. Config in, busy/valid/candidate out.
interface set_counter_multi_if #(
  parameter int COORD_W = 4,
  parameter int GRID    = 8,
  parameter int NCIRC   = 3
);
  import set_pkg::*;

  localparam int CNT_W = cnt_w(GRID);
  localparam int TH_W  = th_w(NCIRC);

  logic                         en;
  logic [NCIRC*2*COORD_W-1:0]   central;
  logic [NCIRC*COORD_W-1:0]     radius;
  logic [NCIRC-1:0]             mask;
  logic [2:0]                   mode;
  logic [TH_W-1:0]              thresh;
  logic                         busy;
  logic                         valid;
  logic [CNT_W-1:0]             candidate;

  modport master (
    output en, central, radius, mask, mode, thresh,
    input  busy, valid, candidate
  );

  modport slave (
    input  en, central, radius, mask, mode, thresh,
    output busy, valid, candidate
  );

endinterface

// File: rtl/set_circle_test.sv
// One circle: stage 1 registers d2 of the issued point,
// stage 2 compares against r^2 and applies the mask bit.
module set_circle_test #(
  parameter int COORD_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               v_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [COORD_W-1:0] cx_i,
  input  logic [COORD_W-1:0] cy_i,
  input  logic [COORD_W-1:0] r_i,
  input  logic               m_i,
  output logic               v_o,
  output logic               in_o
);

  localparam int D2W = 2 * COORD_W + 1;

  logic signed [COORD_W:0]   dx;
  logic signed [COORD_W:0]   dy;
  logic [COORD_W-1:0]        ax;
  logic [COORD_W-1:0]        ay;
  logic [2*COORD_W-1:0]      sx;
  logic [2*COORD_W-1:0]      sy;
  logic [2*COORD_W-1:0]      r2;
  logic [D2W-1:0]            d2_d;
  logic [D2W-1:0]            d2_q;
  logic                      v_q;

  assign dx = $signed({1'b0, x_i}) - $signed({1'b0, cx_i});
  assign dy = $signed({1'b0, y_i}) - $signed({1'b0, cy_i});

  // |d| never exceeds 2**COORD_W-1, so it fits COORD_W bits
  assign ax = dx[COORD_W] ? COORD_W'(-dx) : dx[COORD_W-1:0];
  assign ay = dy[COORD_W] ? COORD_W'(-dy) : dy[COORD_W-1:0];

  assign sx = {{COORD_W{1'b0}}, ax} * {{COORD_W{1'b0}}, ax};
  assign sy = {{COORD_W{1'b0}}, ay} * {{COORD_W{1'b0}}, ay};
  assign r2 = {{COORD_W{1'b0}}, r_i} * {{COORD_W{1'b0}}, r_i};

  assign d2_d = {1'b0, sx} + {1'b0, sy};

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q  <= 1'b0;
      d2_q <= '0;
    end else begin
      v_q  <= v_i;
      d2_q <= d2_d;
    end
  end

  assign v_o  = v_q;
  assign in_o = m_i & v_q & (d2_q <= {1'b0, r2});

endmodule

// File: rtl/set_counter_multi.sv
// Scans the GRIDxGRID lattice one point per cycle and counts
// points matching a set expression over NCIRC circles.
module set_counter_multi
  import set_pkg::*;
#(
  parameter int COORD_W = 4,
  parameter int GRID    = 8,
  parameter int NCIRC   = 3
) (
  input logic               clk,
  input logic               rst,
  set_counter_multi_if.slave bus
);

  localparam int CNT_W = cnt_w(GRID);
  localparam int TH_W  = th_w(NCIRC);
  localparam logic [COORD_W-1:0] GMAX = COORD_W'(GRID);
  localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);

  state_e                      st_q, st_d;
  logic [1:0]                  dc_q;
  logic [COORD_W-1:0]          x_q, y_q;
  logic                        pv_q;
  logic [COORD_W-1:0]          px_q, py_q;
  logic [NCIRC*2*COORD_W-1:0]  cen_q;
  logic [NCIRC*COORD_W-1:0]    rad_q;
  logic [NCIRC-1:0]            mask_q;
  logic [2:0]                  mode_q;
  logic [TH_W-1:0]             th_q;
  logic [CNT_W-1:0]            acc_q, acc_d;
  logic [CNT_W-1:0]            cand_q;
  logic [NCIRC-1:0]            v_vec;
  logic [NCIRC-1:0]            in_vec;
  logic [TH_W-1:0]             pc;
  logic                        v1;
  logic                        hit;
  logic                        start;
  logic                        last_pt;

  assign start   = bus.en & ((st_q == ST_IDLE) | (st_q == ST_DONE));
  assign last_pt = (x_q == GMAX) & (y_q == GMAX);

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_IDLE:  if (start) st_d = ST_SCAN;
      ST_SCAN:  if (last_pt) st_d = ST_DRAIN;
      ST_DRAIN: if (dc_q == 2'(DRAIN_CYC - 1)) st_d = ST_DONE;
      ST_DONE:  st_d = start ? ST_SCAN : ST_IDLE;
      default:  st_d = ST_IDLE;
    endcase
  end

  for (genvar i = 0; i < NCIRC; i++) begin : g_c
    set_circle_test #(.COORD_W(COORD_W)) u_c (
      .clk  (clk),
      .rst  (rst),
      .v_i  (pv_q),
      .x_i  (px_q),
      .y_i  (py_q),
      .cx_i (cen_q[(2*i+1)*COORD_W +: COORD_W]),
      .cy_i (cen_q[2*i*COORD_W +: COORD_W]),
      .r_i  (rad_q[i*COORD_W +: COORD_W]),
      .m_i  (mask_q[i]),
      .v_o  (v_vec[i]),
      .in_o (in_vec[i])
    );
  end

  // all circle stages carry the same valid bit
  assign v1 = &v_vec;

  always_comb begin
    pc = '0;
    for (int i = 0; i < NCIRC; i++) begin
      pc = pc + TH_W'(in_vec[i]);
    end
  end

  always_comb begin
    hit = 1'b0;
    unique case (1'b1)
      (mode_q == MODE_C0):  hit = in_vec[0];
      (mode_q == MODE_AND): hit = (|mask_q) & (&(in_vec | ~mask_q));
      (mode_q == MODE_XOR): hit = ^in_vec;
      (mode_q == MODE_OR):  hit = |in_vec;
      (mode_q == MODE_KOF): hit = (pc >= th_q);
      default:              hit = 1'b0;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    if (start) acc_d = '0;
    else if (v1 & hit) acc_d = acc_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      dc_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      pv_q   <= 1'b0;
      px_q   <= '0;
      py_q   <= '0;
      cen_q  <= '0;
      rad_q  <= '0;
      mask_q <= '0;
      mode_q <= '0;
      th_q   <= '0;
      acc_q  <= '0;
      cand_q <= '0;
    end else begin
      st_q  <= st_d;
      acc_q <= acc_d;
      pv_q  <= (st_q == ST_SCAN);
      px_q  <= x_q;
      py_q  <= y_q;
      dc_q  <= (st_q == ST_DRAIN) ? dc_q + 2'd1 : 2'd0;
      if (start) begin
        cen_q  <= bus.central;
        rad_q  <= bus.radius;
        mask_q <= bus.mask;
        mode_q <= bus.mode;
        th_q   <= bus.thresh;
        x_q    <= ONE;
        y_q    <= ONE;
      end else if (st_q == ST_SCAN) begin
        if (x_q == GMAX) begin
          x_q <= ONE;
          y_q <= y_q + ONE;
        end else begin
          x_q <= x_q + ONE;
        end
      end
      if ((st_q == ST_DRAIN) & (st_d == ST_DONE)) begin
        cand_q <= acc_q;
      end
    end
  end

  assign bus.busy      = (st_q == ST_SCAN) | (st_q == ST_DRAIN);
  assign bus.valid     = (st_q == ST_DONE);
  assign bus.candidate = cand_q;

endmodule
